// File: rtl/count_sequencer_pkg.sv
// Shared types and default sizes for the counter sequencer.
package count_seq_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int HOLD_W_DEF = 8;
    localparam int PASS_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        HOLD,
        DONE
    } seq_state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// Control/status bundle between the register layer, the sequencer and the counter.
// master: register layer plus counter instance; slave: the sequencer.
interface count_sequencer_if
    import count_seq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int PASS_W = PASS_W_DEF
) ();

    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  target;
    logic [HOLD_W-1:0] hold_cycles;
    logic              repeat_en;
    logic [WIDTH-1:0]  count;
    logic              cnt_rst;
    logic              cnt_en;
    logic              busy;
    logic              done;
    logic [PASS_W-1:0] passes;

    modport master (
        output start, abort, target, hold_cycles, repeat_en, count,
        input  cnt_rst, cnt_en, busy, done, passes
    );

    modport slave (
        input  start, abort, target, hold_cycles, repeat_en, count,
        output cnt_rst, cnt_en, busy, done, passes
    );

endinterface

// File: rtl/count_sequencer_dwell_timer.sv
// Loadable down-counter timing the HOLD dwell; last flags the final cycle.
module dwell_timer #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              tick,
    output logic              last,
    output logic [HOLD_W-1:0] value
);

    logic [HOLD_W-1:0] value_q;

    // Load takes priority over counting; the counter parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (tick && (value_q != '0)) begin
            value_q <= value_q - HOLD_W'(1);
        end
    end

    assign value = value_q;
    assign last  = (value_q == HOLD_W'(1));

endmodule

// File: rtl/count_sequencer.sv
// Sequences an external counter: clear, count to target, dwell, report, repeat.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// CLEAR | counter rst asserted for one cycle
// RUN   | counter enabled until count equals target
// HOLD  | dwell for hold cycles, counter frozen
// DONE  | one-cycle done pulse, pass counted
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int PASS_W = PASS_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    count_sequencer_if.slave   bus
);

    seq_state_t        state_q, state_d;
    logic [WIDTH-1:0]  target_q;
    logic [HOLD_W-1:0] hold_q;
    logic              repeat_q;
    logic [PASS_W-1:0] passes_q;

    logic              accept;
    logic              tmr_load;
    logic              tmr_tick;
    logic              tmr_last;
    logic [HOLD_W-1:0] tmr_value;
    logic              pass_inc;
    logic              at_target;

    assign at_target = (bus.count == target_q);

    dwell_timer #(.HOLD_W(HOLD_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (hold_q),
        .tick     (tmr_tick),
        .last     (tmr_last),
        .value    (tmr_value)
    );

    // Next-state and strobe decode; abort overrides every transition.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        tmr_load = 1'b0;
        tmr_tick = 1'b0;
        pass_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = RUN;
            RUN: begin
                if (at_target) begin
                    if (hold_q != '0) begin
                        tmr_load = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            HOLD: begin
                tmr_tick = (tmr_value != '0);
                if (tmr_last) state_d = DONE;
            end
            DONE: begin
                pass_inc = 1'b1;
                state_d  = repeat_q ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort) begin
            state_d  = IDLE;
            accept   = 1'b0;
            tmr_load = 1'b0;
            tmr_tick = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Run configuration is captured only when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            hold_q   <= '0;
            repeat_q <= 1'b0;
        end else if (accept) begin
            target_q <= bus.target;
            hold_q   <= bus.hold_cycles;
            repeat_q <= bus.repeat_en;
        end
    end

    // Completed-pass counter, cleared by each accepted start, kept across abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        passes_q <= '0;
        else if (accept)   passes_q <= '0;
        else if (pass_inc) passes_q <= passes_q + PASS_W'(1);
    end

    // Enable drops combinationally at equality so the counter never overshoots.
    assign bus.cnt_rst = (state_q == CLEAR);
    assign bus.cnt_en  = (state_q == RUN) && !at_target && !bus.abort;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.passes  = passes_q;

endmodule
